ama_riscv_uart_mmio: RTL

// - MMIO UART peripheral behind the core's MMIO_RANGE (4'b0101) decode; consumes load/store requests from the MEM stage.
// - Exposes 3 word registers {ctrl, rx_data, tx_data} (UART_SIZE = 12 B) and drives/samples 8N1 serial lines.
// - Read data is returned one cycle after the request, with the same timing as a dcache load hit.

---
 rtl/ama_riscv_uart_mmio.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/ama_riscv_uart_mmio.sv
// MMIO UART peripheral: three word registers (ctrl, rx_data, tx_data) decoded by the core,
// an 8N1 transmitter and a mid-bit sampling 8N1 receiver behind a 2-flop synchronizer.
module ama_riscv_uart_mmio #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD        = 115_200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_rtype,
    input  logic [1:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    input  logic        serial_in,
    output logic        serial_out
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic       DMEM_READ  = 1'b0;
    localparam logic       DMEM_WRITE = 1'b1;

    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_RX   = 2'd1;
    localparam logic [1:0] ADDR_TX   = 2'd2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // ---------------- request decode ----------------
    logic tx_wr;
    logic rx_rd;
    logic rd_req;

    assign rd_req = req_valid && (req_rtype == DMEM_READ);
    assign tx_wr  = req_valid && (req_rtype == DMEM_WRITE) && (req_addr == ADDR_TX);
    assign rx_rd  = rd_req && (req_addr == ADDR_RX);

    // ---------------- transmitter ----------------
    logic [1:0]       tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             serial_out_q, serial_out_d;
    logic             tx_ready;

    // tx_ready is purely a function of state so a write in the last STOP cycle is dropped
    assign tx_ready = (tx_state_q == S_IDLE);

    always_comb begin
        tx_state_d   = tx_state_q;
        tx_cnt_d     = tx_cnt_q;
        tx_bit_d     = tx_bit_q;
        tx_shift_d   = tx_shift_q;
        serial_out_d = serial_out_q;
        case (tx_state_q)
            S_IDLE: begin
                if (tx_wr) begin
                    tx_state_d   = S_START;
                    tx_cnt_d     = '0;
                    tx_bit_d     = 3'd0;
                    tx_shift_d   = req_wdata[7:0];
                    serial_out_d = 1'b0;
                end
            end
            S_START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_state_d   = S_DATA;
                    tx_cnt_d     = '0;
                    serial_out_d = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d   = S_STOP;
                        serial_out_d = 1'b1;
                    end else begin
                        tx_bit_d     = tx_bit_q + 3'd1;
                        tx_shift_d   = {1'b0, tx_shift_q[7:1]};
                        serial_out_d = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_state_d = S_IDLE;
                    tx_cnt_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q   <= S_IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= 3'd0;
            tx_shift_q   <= 8'h00;
            serial_out_q <= 1'b1;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            serial_out_q <= serial_out_d;
        end
    end

    assign serial_out = serial_out_q;

    // ---------------- receiver ----------------
    logic             rx_sync1_q, rx_sync2_q, rx_prev_q;
    logic [1:0]       rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_valid_q, rx_valid_d;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_byte_d  = rx_byte_q;
        // completion below overrides the read-clear, so a coinciding read keeps rx_valid set
        rx_valid_d = rx_valid_q && !rx_rd;
        case (rx_state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_sync2_q) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = '0;
                end
            end
            S_START: begin
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d = '0;
                    rx_bit_d = 3'd0;
                    rx_state_d = rx_sync2_q ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = S_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_state_d = S_IDLE;
                    rx_cnt_d   = '0;
                    if (rx_sync2_q) begin
                        rx_byte_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_byte_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            rx_sync1_q <= serial_in;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // ---------------- read response ----------------
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;

    always_comb begin
        rsp_valid_d = rd_req;
        rsp_data_d  = 32'h0;
        if (rd_req) begin
            case (req_addr)
                ADDR_CTRL: rsp_data_d = {30'b0, rx_valid_q, tx_ready};
                ADDR_RX:   rsp_data_d = {24'b0, rx_byte_q};
                default:   rsp_data_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule
